// File: rtl/nn_frame_loader.sv
// Serial-to-parallel frame loader for the neuron datapath: collects N activations,
// N*M*K weights and a bias from a byte stream, then holds them until acknowledged.
module nn_frame_loader #(
    parameter int N  = 4,
    parameter int M  = 4,
    parameter int K  = 3,
    parameter int DW = 8,
    parameter int WW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DW*N-1:0]       data_out,
    output logic [WW*N*M*K-1:0]   weight_out,
    output logic [DW-1:0]         bias_out,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic                  frame_err,
    output logic [7:0]            err_count
);
    localparam int NW  = N * M * K;
    localparam int XW  = (N > 1)  ? $clog2(N)  : 1;
    localparam int WIX = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW  = (XW > WIX) ? XW : WIX;

    typedef enum logic [1:0] {LOAD_X, LOAD_W, LOAD_B, HOLD} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [N-1:0][DW-1:0]    r_data;
    logic [NW-1:0][WW-1:0]   r_weight;
    logic [DW-1:0]           r_bias;
    logic                    r_err;
    logic [7:0]              r_err_cnt;

    logic w_acc, w_wr_x, w_wr_w, w_wr_b, w_err;

    assign s_ready     = (r_state != HOLD);
    assign w_acc       = s_valid & s_ready;
    assign frame_valid = (r_state == HOLD);
    assign data_out    = r_data;
    assign weight_out  = r_weight;
    assign bias_out    = r_bias;
    assign frame_err   = r_err;
    assign err_count   = r_err_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_x      = 1'b0;
        w_wr_w      = 1'b0;
        w_wr_b      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            LOAD_X: if (w_acc) begin
                if (s_last) begin
                    w_err       = 1'b1;
                    w_idx_nxt   = '0;
                end else begin
                    w_wr_x = 1'b1;
                    if (r_idx == IW'(N - 1)) begin
                        w_state_nxt = LOAD_W;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            LOAD_W: if (w_acc) begin
                if (s_last) begin
                    w_err       = 1'b1;
                    w_state_nxt = LOAD_X;
                    w_idx_nxt   = '0;
                end else begin
                    w_wr_w = 1'b1;
                    if (r_idx == IW'(NW - 1)) begin
                        w_state_nxt = LOAD_B;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            LOAD_B: if (w_acc) begin
                w_idx_nxt = '0;
                if (s_last) begin
                    w_wr_b      = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = LOAD_X;
                end
            end
            HOLD: if (frame_ack) begin
                w_state_nxt = LOAD_X;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = LOAD_X;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LOAD_X;
            r_idx     <= '0;
            r_data    <= '0;
            r_weight  <= '0;
            r_bias    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err;
            if (w_wr_x) r_data[r_idx[XW-1:0]]      <= s_data;
            if (w_wr_w) r_weight[r_idx[WIX-1:0]]   <= s_data[WW-1:0];
            if (w_wr_b) r_bias                      <= s_data;
            // Saturate rather than wrap so a flood of bad frames stays visible.
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
endmodule

// File: doc/nn_frame_loader.md
Name: nn_frame_loader

Overview:
- Upstream stage of the multi-layer neuron datapath.
- Accepts one serial byte stream per inference frame over a valid/ready handshake. Each frame holds N input activations, then N*M*K weights, then one bias word.
- Assembles the frame into the parallel arrays the layer engine consumes (data_in, weight_in, bias).
- Holds the assembled frame stable until the engine acknowledges it. Malformed frames are detected and discarded.

Parameters:
- N, 4, inputs per neuron (activation count).
- M, 4, neurons per layer.
- K, 3, number of layers.
- DW, 8, stream, activation and bias width.
- WW, 8, weight width; WW<=DW; a weight is the low WW bits of its beat.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  stream beat valid.
- s_data  in  DW  stream beat payload.
- s_last  in  1  marks the final beat of a frame.
- s_ready  out  1  loader can accept a beat.
- data_out  out  DW x N  assembled activations, element i = beat i.
- weight_out  out  WW x (N*M*K)  assembled weights, element j = beat N+j.
- bias_out  out  DW  assembled bias, beat N+N*M*K.
- frame_valid  out  1  all outputs hold a complete, well-formed frame.
- frame_ack  in  1  consumer has latched the frame.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- err_count  out  8  saturating count of malformed frames.

Behaviour:
- Frame length: T = N + N*M*K + 1 beats. A beat is accepted when s_valid & s_ready at a rising edge.
- FSM states: LOAD_X (reset state), LOAD_W, LOAD_B, HOLD. One index counter idx, sized for max(N, N*M*K).
- s_ready = 1 in LOAD_X, LOAD_W and LOAD_B; s_ready = 0 in HOLD. There is no double buffering.
- LOAD_X: the accepted beat is written to data_out[idx]. When idx==N-1, go to LOAD_W with idx=0; otherwise idx++.
- LOAD_W: the accepted beat's low WW bits are written to weight_out[idx]. When idx==N*M*K-1, go to LOAD_B with idx=0; otherwise idx++.
- LOAD_B: the accepted beat is written to bias_out.
  - If s_last=1, go to HOLD. frame_valid rises on the same edge, so latency from the last accepted beat to frame_valid is 0 cycles after the edge.
  - If s_last=0, the frame is malformed (see error handling below).
- HOLD: data_out, weight_out and bias_out are stable and frame_valid=1. When frame_ack=1 at an edge, go to LOAD_X with idx=0; frame_valid=0 and s_ready=1 from that edge on.
- frame_ack outside HOLD is ignored.
- Error handling (malformed frame):
  - Cases: s_last=1 on an accepted beat that is not beat T-1, or s_last=0 on the bias beat.
  - The beat is discarded (not written), frame_err pulses high for exactly one cycle, and err_count increments, saturating at 255.
  - State returns to LOAD_X with idx=0. The next accepted beat is treated as beat 0 of a new frame.
  - Partially overwritten output registers are don't-care; frame_valid stays 0.
- s_valid=0 in any load state: idx and state are held, nothing is written. Gaps of any length are legal.
- s_data and s_last are sampled only on accepted beats; they are don't-care otherwise.
- Reset (asynchronous, valid at any time, including mid-frame or in HOLD):
  - state=LOAD_X, idx=0.
  - frame_valid=0, frame_err=0, err_count=0.
  - data_out, weight_out and bias_out all zero.
  - s_ready=1 after reset deasserts.
- Output registers change only on accepted beats or reset.

Test Plan:
1. Defaults N=4, M=4, K=3 (T=53). Send beats s_data=k for k=0..52 with s_last on beat 52, continuous valid -> frame_valid rises after beat 52's edge; data_out = {0,1,2,3}, weight_out[j] = 4+j, bias_out = 52, s_ready=0 while in HOLD.
2. Same frame with s_valid deasserted for 3 cycles after every 5th beat -> identical outputs; idx does not advance during the gaps.
3. Hold frame_ack=0 for 10 cycles, then pulse it for 1 cycle, then send a second frame with s_data=100+k -> outputs are stable for the 10 cycles; after the ack, frame_valid=0 and s_ready=1 on the next cycle; the second frame appears with bias_out=152.
4. s_last asserted on beat 20 -> frame_err pulses 1 cycle, err_count=1, no frame_valid; a following correct 53-beat frame is assembled correctly.
5. s_last=0 on beat 52 -> frame_err pulse, err_count increments, state LOAD_X. 256 such errors -> err_count saturates at 255.
6. Assert rst_n=0 at beat 30, and separately during HOLD -> all outputs zero, frame_valid=0, err_count=0; a full frame after reset loads correctly.
